// File: rtl/mmu_bus_arbiter.sv
// mmu_bus_arbiter: two-port arbiter and ADDR/DATA/DONE cycle sequencer for the mmu8722 register bus
module mmu_bus_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        reset_i_n,
  input  logic        p0_req_i,
  input  logic        p0_rw_i,
  input  logic [15:0] p0_addr_i,
  input  logic [7:0]  p0_wdata_i,
  output logic        p0_ack_o,
  output logic [7:0]  p0_rdata_o,
  input  logic        p1_req_i,
  input  logic        p1_rw_i,
  input  logic [15:0] p1_addr_i,
  input  logic [7:0]  p1_wdata_i,
  output logic        p1_ack_o,
  output logic [7:0]  p1_rdata_o,
  output logic [15:0] mmu_addr_o,
  output logic        mmu_rw_o,
  output logic [7:0]  mmu_d_o,
  output logic        mmu_d_oe_o,
  input  logic [7:0]  mmu_d_i,
  output logic        busy_o,
  output logic        grant_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0]  state;
  logic [3:0]  starve_cnt;
  logic        rw_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        any_req, win1, active;
  assign any_req = p0_req_i | p1_req_i;
  assign win1    = p1_req_i & (~p0_req_i | (starve_cnt == 4'(STARVE_MAX)));
  assign active  = (state == ADDR) | (state == DATA);
  // The state encoding is ordered so DONE wraps to IDLE on increment.
  always_ff @(posedge clk_i) begin
    if (!reset_i_n) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      grant_o    <= 1'b0;
      rw_q       <= 1'b1;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      p0_rdata_o <= 8'h00;
      p1_rdata_o <= 8'h00;
    end else begin
      state <= (state == IDLE && !any_req) ? IDLE : state + 2'd1;
      if (state == IDLE) begin
        starve_cnt <= (!p1_req_i || win1) ? 4'd0 :
                      (p0_req_i && starve_cnt != 4'(STARVE_MAX)) ? starve_cnt + 4'd1 : starve_cnt;
        if (any_req) begin
          grant_o <= win1;
          rw_q    <= win1 ? p1_rw_i : p0_rw_i;
          addr_q  <= win1 ? p1_addr_i : p0_addr_i;
          wdata_q <= win1 ? p1_wdata_i : p0_wdata_i;
        end
      end
      if (state == DATA && rw_q && !grant_o) p0_rdata_o <= mmu_d_i;
      if (state == DATA && rw_q && grant_o) p1_rdata_o <= mmu_d_i;
    end
  end
  assign mmu_addr_o = active ? addr_q : 16'h0000;
  assign mmu_rw_o   = active ? rw_q : 1'b1;
  assign mmu_d_oe_o = active & ~rw_q;
  assign mmu_d_o    = mmu_d_oe_o ? wdata_q : 8'h00;
  assign busy_o     = state != IDLE;
  assign p0_ack_o   = (state == DONE) & ~grant_o;
  assign p1_ack_o   = (state == DONE) & grant_o;
endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// tb_mmu_bus_arbiter: directed self-checking bench with a small MMU register model
module tb_mmu_bus_arbiter;
  logic        clk_i = 1'b0;
  logic        reset_i_n = 1'b0;
  logic        p0_req_i = 1'b0, p0_rw_i = 1'b1;
  logic [15:0] p0_addr_i = 16'h0;
  logic [7:0]  p0_wdata_i = 8'h0;
  logic        p0_ack_o;
  logic [7:0]  p0_rdata_o;
  logic        p1_req_i = 1'b0, p1_rw_i = 1'b1;
  logic [15:0] p1_addr_i = 16'h0;
  logic [7:0]  p1_wdata_i = 8'h0;
  logic        p1_ack_o;
  logic [7:0]  p1_rdata_o;
  logic [15:0] mmu_addr_o;
  logic        mmu_rw_o, mmu_d_oe_o, busy_o, grant_o;
  logic [7:0]  mmu_d_o, mmu_d_i;
  logic [7:0]  mem [256];
  int checks = 0, errors = 0;
  logic [5:0]  exp_g = 6'b010000;
  mmu_bus_arbiter #(.STARVE_MAX(4)) dut (
    .clk_i(clk_i), .reset_i_n(reset_i_n),
    .p0_req_i(p0_req_i), .p0_rw_i(p0_rw_i), .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
    .p0_ack_o(p0_ack_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_rw_i(p1_rw_i), .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
    .p1_ack_o(p1_ack_o), .p1_rdata_o(p1_rdata_o),
    .mmu_addr_o(mmu_addr_o), .mmu_rw_o(mmu_rw_o), .mmu_d_o(mmu_d_o), .mmu_d_oe_o(mmu_d_oe_o),
    .mmu_d_i(mmu_d_i), .busy_o(busy_o), .grant_o(grant_o)
  );
  always #5 clk_i = ~clk_i;
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge clk_i) if (!mmu_rw_o && mmu_d_oe_o) mem[mmu_addr_o[7:0]] <= mmu_d_o;
  assign mmu_d_i = mem[mmu_addr_o[7:0]];
  task automatic step();
    @(negedge clk_i);
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_addr"}, mmu_addr_o, 16'h0000);
    chk({tag, "_rw"}, 16'(mmu_rw_o), 16'h1);
    chk({tag, "_oe"}, 16'(mmu_d_oe_o), 16'h0);
    chk({tag, "_d"}, 16'(mmu_d_o), 16'h00);
  endtask
  initial begin
    step(); step();
    chk_idle("rst");
    chk("rst_busy", 16'(busy_o), 16'h0);
    chk("rst_grant", 16'(grant_o), 16'h0);
    chk("rst_ack", {14'h0, p1_ack_o, p0_ack_o}, 16'h0);
    chk("rst_rd0", 16'(p0_rdata_o), 16'h00);
    chk("rst_rd1", 16'(p1_rdata_o), 16'h00);
    reset_i_n = 1'b1;
    step();
    // port-0 write D500 = 55
    p0_req_i = 1'b1; p0_rw_i = 1'b0; p0_addr_i = 16'hD500; p0_wdata_i = 8'h55;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("wr_addr", mmu_addr_o, 16'hD500);
      chk("wr_rw", 16'(mmu_rw_o), 16'h0);
      chk("wr_oe", 16'(mmu_d_oe_o), 16'h1);
      chk("wr_d", 16'(mmu_d_o), 16'h55);
      chk("wr_ack_early", 16'(p0_ack_o), 16'h0);
      chk("wr_busy", 16'(busy_o), 16'h1);
    end
    step();
    chk("wr_ack", {14'h0, p1_ack_o, p0_ack_o}, 16'h1);
    chk_idle("wr_done");
    p0_req_i = 1'b0;
    step();
    chk("wr_after_busy", 16'(busy_o), 16'h0);
    chk("wr_after_ack", 16'(p0_ack_o), 16'h0);
    // port-1 read D500
    p1_req_i = 1'b1; p1_rw_i = 1'b1; p1_addr_i = 16'hD500;
    step();
    chk("rd_grant", 16'(grant_o), 16'h1);
    chk("rd_addr", mmu_addr_o, 16'hD500);
    chk("rd_oe", 16'(mmu_d_oe_o), 16'h0);
    step(); step();
    chk("rd_ack", {14'h0, p1_ack_o, p0_ack_o}, 16'h2);
    chk("rd_data1", 16'(p1_rdata_o), 16'h55);
    chk("rd_data0", 16'(p0_rdata_o), 16'h00);
    p1_req_i = 1'b0;
    step();
    chk("rd_hold", 16'(p1_rdata_o), 16'h55);
    // simultaneous: p0 write D501=11, p1 read D501
    p0_req_i = 1'b1; p0_rw_i = 1'b0; p0_addr_i = 16'hD501; p0_wdata_i = 8'h11;
    p1_req_i = 1'b1; p1_rw_i = 1'b1; p1_addr_i = 16'hD501;
    step();
    chk("sim_grant0", 16'(grant_o), 16'h0);
    step(); step();
    chk("sim_ack0", {14'h0, p1_ack_o, p0_ack_o}, 16'h1);
    p0_req_i = 1'b0;
    step(); step(); step();
    chk("sim_ack1_early", 16'(p1_ack_o), 16'h0);
    step();
    chk("sim_ack1", {14'h0, p1_ack_o, p0_ack_o}, 16'h2);
    chk("sim_rdata1", 16'(p1_rdata_o), 16'h11);
    p1_req_i = 1'b0;
    step();
    // starvation: both hold requests; p0 reads D500, p1 reads D501
    p0_req_i = 1'b1; p0_rw_i = 1'b1; p0_addr_i = 16'hD500;
    p1_req_i = 1'b1; p1_rw_i = 1'b1; p1_addr_i = 16'hD501;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("starve_grant%0d", k), 16'(grant_o), 16'(exp_g[k]));
      step(); step();
      chk($sformatf("starve_ack%0d", k), {14'h0, p1_ack_o, p0_ack_o}, exp_g[k] ? 16'h2 : 16'h1);
      if (k == 5) begin p0_req_i = 1'b0; p1_req_i = 1'b0; end
      step();
    end
    chk("starve_rd0", 16'(p0_rdata_o), 16'h55);
    chk("starve_rd1", 16'(p1_rdata_o), 16'h11);
    // reset during DATA of a write
    p0_req_i = 1'b1; p0_rw_i = 1'b0; p0_addr_i = 16'hD502; p0_wdata_i = 8'h77;
    step(); step();
    chk("mr_data_phase", 16'(mmu_d_oe_o), 16'h1);
    reset_i_n = 1'b0; p0_req_i = 1'b0;
    step();
    chk_idle("mr");
    chk("mr_ack", {14'h0, p1_ack_o, p0_ack_o}, 16'h0);
    chk("mr_busy", 16'(busy_o), 16'h0);
    chk("mr_rd0", 16'(p0_rdata_o), 16'h00);
    chk("mr_rd1", 16'(p1_rdata_o), 16'h00);
    reset_i_n = 1'b1;
    step();
    chk("mr_no_ack", 16'(p0_ack_o), 16'h0);
    p0_req_i = 1'b1; p0_rw_i = 1'b1; p0_addr_i = 16'hD500;
    step(); step(); step();
    chk("mr_post_ack", 16'(p0_ack_o), 16'h1);
    chk("mr_post_rd", 16'(p0_rdata_o), 16'h55);
    p0_req_i = 1'b0;
    step();
    // back-to-back on port 0: write D505=01 then read D505
    p0_req_i = 1'b1; p0_rw_i = 1'b0; p0_addr_i = 16'hD505; p0_wdata_i = 8'h01;
    step(); step(); step();
    chk("b2b_ack1", 16'(p0_ack_o), 16'h1);
    p0_rw_i = 1'b1;
    step();
    chk("b2b_idle_ack", 16'(p0_ack_o), 16'h0);
    step();
    chk("b2b_rd_addr", mmu_addr_o, 16'hD505);
    chk("b2b_rd_rw", 16'(mmu_rw_o), 16'h1);
    step();
    chk("b2b_ack_early", 16'(p0_ack_o), 16'h0);
    step();
    chk("b2b_ack2", 16'(p0_ack_o), 16'h1);
    chk("b2b_rdata", 16'(p0_rdata_o), 16'h01);
    p0_req_i = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
